// File: rtl/timer_tick_multi.sv
// Multi-channel timebase: per-channel programmable terminal count, one-cycle tick and 50% clk_out.
// Optional one-shot mode with per-channel done flag when TIMER_ONESHOT_EN is defined.
module timer_tick_multi #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEFAULT_TC = 24999,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_tc,
  output logic [NUM_CH-1:0] tick,
`ifdef TIMER_ONESHOT_EN
  input  logic [NUM_CH-1:0] oneshot,
  output logic [NUM_CH-1:0] done,
`endif
  output logic [NUM_CH-1:0] clk_out
);

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  tc_q  [NUM_CH];
  logic [CNT_W-1:0]  tc_d  [NUM_CH];
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
`ifdef TIMER_ONESHOT_EN
  logic [NUM_CH-1:0] done_q, done_d;
`endif

  always_comb begin
    tick_d    = '0;
    clk_out_d = clk_out_q;
`ifdef TIMER_ONESHOT_EN
    done_d    = done_q;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      tc_d[i]  = tc_q[i];
      if (clr) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
`ifdef TIMER_ONESHOT_EN
        done_d[i]    = 1'b0;
`endif
      end else if (cfg_we && (cfg_ch == CH_W'(i))) begin
        // A write wins over a coincident terminal count; that tick is dropped.
        tc_d[i]  = cfg_tc;
        cnt_d[i] = '0;
`ifdef TIMER_ONESHOT_EN
        done_d[i] = 1'b0;
`endif
      end else if (!en[i]) begin
`ifdef TIMER_ONESHOT_EN
        done_d[i] = 1'b0;
`endif
      end
`ifdef TIMER_ONESHOT_EN
      else if (done_q[i]) begin
        cnt_d[i] = '0;
      end
`endif
      else if (cnt_q[i] == tc_q[i]) begin
        cnt_d[i]     = '0;
        tick_d[i]    = 1'b1;
        clk_out_d[i] = ~clk_out_q[i];
`ifdef TIMER_ONESHOT_EN
        done_d[i]    = oneshot[i];
`endif
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        tc_q[i]  <= CNT_W'(DEFAULT_TC);
      end
      tick_q    <= '0;
      clk_out_q <= '0;
`ifdef TIMER_ONESHOT_EN
      done_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        tc_q[i]  <= tc_d[i];
      end
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
`ifdef TIMER_ONESHOT_EN
      done_q    <= done_d;
`endif
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
`ifdef TIMER_ONESHOT_EN
  assign done    = done_q;
`endif

endmodule

// File: tb/tb_timer_tick_multi.sv
// Directed self-checking bench for timer_tick_multi; a second NUM_CH=3 instance covers out-of-range cfg_ch.
module tb_timer_tick_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_tc;
  logic [3:0]  tick;
  logic [3:0]  clk_out;
`ifdef TIMER_ONESHOT_EN
  logic [3:0]  oneshot;
  logic [3:0]  done;
  logic [2:0]  done3;
`endif

  logic        clr3;
  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [7:0]  cfg_tc3;
  logic [2:0]  tick3;
  logic [2:0]  clk_out3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  timer_tick_multi #(.NUM_CH(4), .CNT_W(16), .DEFAULT_TC(24999)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_tc  (cfg_tc),
    .tick    (tick),
`ifdef TIMER_ONESHOT_EN
    .oneshot (oneshot),
    .done    (done),
`endif
    .clk_out (clk_out)
  );

  timer_tick_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_TC(5)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr3),
    .en      (3'b111),
    .cfg_we  (cfg_we3),
    .cfg_ch  (cfg_ch3),
    .cfg_tc  (cfg_tc3),
    .tick    (tick3),
`ifdef TIMER_ONESHOT_EN
    .oneshot (3'b000),
    .done    (done3),
`endif
    .clk_out (clk_out3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until tick[ch] is seen; n is the number of edges taken (max on timeout).
  task automatic wait_tick(input int ch, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < max);
  endtask

  initial begin
    int         n;
    logic       acc;
    logic [15:0] tseq, cseq;

    rst_n = 1'b0; clr = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_tc = '0;
    clr3 = 1'b0; cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_tc3 = '0;
`ifdef TIMER_ONESHOT_EN
    oneshot = '0;
`endif
    step(); step();
    check("rst_tick", 32'(tick), 0);
    check("rst_clk_out", 32'(clk_out), 0);
    rst_n = 1'b1;

    // Default terminal count: first tick 25000 edges after enable.
    en = 4'b0001;
    wait_tick(0, 26000, n);
    check("t1_first_tick", n, 25000);
    check("t1_clk_out0", 32'(clk_out[0]), 1);
    check("t1_idle_tick", 32'(tick[3:1]), 0);
    check("t1_idle_clk_out", 32'(clk_out[3:1]), 0);
    en = '0;
    step();
    check("t1_tick_one_cycle", 32'(tick[0]), 0);

    // ch2 tc=3: tick every 4, clk_out 4 high / 4 low.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_tc = 16'd3;
    step();
    cfg_we = 1'b0; en = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      step();
      tseq[k] = tick[2];
      cseq[k] = clk_out[2];
    end
    check("t2_tick_seq", 32'(tseq), 32'h8888);
    check("t2_clk_seq", 32'(cseq), 32'h7878);
    en = '0;

    // ch1 tc=0: tick every cycle, clk_out = clk/2.
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_tc = 16'd0;
    step();
    cfg_we = 1'b0; en = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      step();
      tseq[k] = tick[1];
      cseq[k] = clk_out[1];
    end
    check("t3_tick_seq", 32'(tseq[7:0]), 32'hff);
    check("t3_clk_seq", 32'(cseq[7:0]), 32'h55);
    en = '0;

    // ch3 tc=9: freeze at cnt=5 for 7 cycles, 5 enabled edges remain.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_tc = 16'd9;
    step();
    cfg_we = 1'b0; en = 4'b1000;
    repeat (5) step();
    en = '0;
    acc = 1'b0;
    repeat (7) begin
      step();
      acc |= tick[3];
    end
    check("t4_no_tick_disabled", 32'(acc), 0);
    en = 4'b1000;
    wait_tick(3, 20, n);
    check("t4_resume", n, 5);
    check("t4_clk_out3", 32'(clk_out[3]), 1);
    // Write coincident with cnt==tc drops the tick and restarts the count.
    repeat (9) step();
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_tc = 16'd9;
    step();
    cfg_we = 1'b0;
    check("t4_wr_drops_tick", 32'(tick[3]), 0);
    check("t4_wr_holds_clk_out", 32'(clk_out[3]), 1);
    wait_tick(3, 20, n);
    check("t4_wr_restart", n, 10);
    check("t4_clk_out3_toggle", 32'(clk_out[3]), 0);

    // Out-of-range cfg_ch on a 3-channel instance touches nothing.
    clr3 = 1'b1;
    step();
    clr3 = 1'b0; cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_tc3 = 8'd1;
    step();
    cfg_we3 = 1'b0;
    n = 1;
    while (!tick3[0] && n < 20) begin
      step();
      n++;
    end
    check("t4_oor_period", n, 6);
    check("t4_oor_all_ch", 32'(tick3), 32'h7);

    // clr clears counts and clk_out but keeps tc.
    en = 4'b1111;
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t5_clr_tick", 32'(tick), 0);
    check("t5_clr_clk_out", 32'(clk_out), 0);
    wait_tick(3, 20, n);
    check("t5_clr_keeps_tc3", n, 10);
    check("t5_clr_keeps_tc1", 32'(tick[1]), 1);

    // Asynchronous reset mid-cycle.
    repeat (2) step();
    check("t5_pre_rst_tick1", 32'(tick[1]), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_async_tick", 32'(tick), 0);
    check("t5_async_clk_out", 32'(clk_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 4'b0110;
    wait_tick(1, 26000, n);
    check("t5_rst_tc1", n, 25000);
    check("t5_rst_tc2", 32'(tick[2]), 1);
    en = '0;
    step();

`ifdef TIMER_ONESHOT_EN
    oneshot = 4'b0001;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_tc = 16'd4;
    step();
    cfg_we = 1'b0; en = 4'b0001;
    wait_tick(0, 20, n);
    check("t6_os_first", n, 5);
    check("t6_os_done_set", 32'(done[0]), 1);
    acc = 1'b0;
    repeat (10) begin
      step();
      acc |= tick[0];
    end
    check("t6_os_no_retick", 32'(acc), 0);
    check("t6_os_done_held", 32'(done[0]), 1);
    en = '0;
    step();
    check("t6_os_done_clr", 32'(done[0]), 0);
    en = 4'b0001;
    wait_tick(0, 20, n);
    check("t6_os_rearm", n, 5);
    en = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
